// File: rtl/framing_pkg.sv
// Shared types and byte constants for the framing datapath blocks.
package framing_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } frame_arb_state_t;

  localparam logic [7:0] DEFAULT_ESCAPE_BYTE = 8'h7D;
  localparam logic [7:0] DEFAULT_START_BYTE  = 8'h7E;
  localparam logic [7:0] DEFAULT_STOP_BYTE   = 8'h7F;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or above last_grant+1, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_req
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    grant_idx = last_grant;
    any_req   = 1'b0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % N);
      if (req[cand]) begin
        grant_idx = cand;
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the tx_frame path, with optional channel-ID prefix.
module frame_arbiter
  import framing_pkg::*;
#(
  parameter int         NR_TARGETS  = 4,
  parameter logic       ADD_HEADER  = 1'b1,
  parameter logic [7:0] HEADER_BASE = 8'h00
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NR_TARGETS-1:0]         target_tvalid,
  output logic [NR_TARGETS-1:0]         target_tready,
  input  logic [NR_TARGETS-1:0][7:0]    target_tdata,
  input  logic [NR_TARGETS-1:0]         target_tlast,
  output logic                          initiator_tvalid,
  input  logic                          initiator_tready,
  output logic [7:0]                    initiator_tdata,
  output logic                          initiator_tlast,
  output logic [$clog2(NR_TARGETS)-1:0] grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(NR_TARGETS);

  frame_arb_state_t state_reg, state_next;
  logic [IW-1:0]    last_grant_reg;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             payload_done;

  rr_arbiter #(.N(NR_TARGETS)) u_rr (
    .req        (target_tvalid),
    .last_grant (last_grant_reg),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  assign payload_done = target_tvalid[grant_id] & initiator_tready & target_tlast[grant_id];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      busy           <= 1'b0;
      grant_id       <= '0;
      last_grant_reg <= IW'(NR_TARGETS - 1);
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != IDLE);
      if (state_reg == IDLE && arb_any) begin
        grant_id       <= arb_idx;
        last_grant_reg <= arb_idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_any) state_next = ADD_HEADER ? HEADER : PAYLOAD;
      HEADER:  if (initiator_tready) state_next = PAYLOAD;
      PAYLOAD: if (payload_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Payload is a zero-latency pass-through of the granted source.
  always_comb begin
    initiator_tvalid = 1'b0;
    initiator_tdata  = 8'h00;
    initiator_tlast  = 1'b0;
    target_tready    = '0;
    case (state_reg)
      HEADER: begin
        initiator_tvalid = 1'b1;
        initiator_tdata  = HEADER_BASE + 8'(grant_id);
      end
      PAYLOAD: begin
        initiator_tvalid        = target_tvalid[grant_id];
        initiator_tdata         = target_tdata[grant_id];
        initiator_tlast         = target_tlast[grant_id];
        target_tready[grant_id] = initiator_tready;
      end
      default: ;
    endcase
  end

endmodule
